bcd_to_binary: RTL and testbench



---
 rtl/bcd_to_binary.sv | 105 ++++++++++
 tb/tb_bcd_to_binary.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One shift/correct step per clock, start/done handshake, invalid-digit flag.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  invalid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BCD_W-1:0]   bcd_r;
  logic [BIN_W-1:0]   bin_r;
  logic [CW-1:0]      cnt;

  logic [BCD_W+BIN_W-1:0] sh;
  logic [BCD_W-1:0]       nxt_bcd;
  logic [BIN_W-1:0]       nxt_bin;
  logic                   bad;

  // Shift right, then pull every digit that reached 8+ back down by 3.
  always_comb begin
    sh      = {bcd_r, bin_r} >> 1;
    nxt_bcd = sh[BCD_W+BIN_W-1:BIN_W];
    nxt_bin = sh[BIN_W-1:0];
    for (int d = 0; d < DIGITS; d++) begin
      if (nxt_bcd[4*d+3])
        nxt_bcd[4*d +: 4] = nxt_bcd[4*d +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      invalid <= 1'b0;
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start && bad) begin
            state   <= DONE;
            done    <= 1'b1;
            invalid <= 1'b1;
            bin_out <= '0;
          end else if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            bcd_r <= bcd_in;
            bin_r <= '0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          bcd_r <= nxt_bcd;
          bin_r <= nxt_bin;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bin_out <= nxt_bin;
            invalid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed-vector bench for bcd_to_binary with hand-computed results.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_bcd_to_binary;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bcd_in;
  logic        busy;
  logic        done;
  logic [13:0] bin_out;
  logic        invalid;

  int errs = 0;
  int checks = 0;
  int lat;
  int busy_n;
  int both;
  int seen;

  bcd_to_binary #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bcd_in(bcd_in),
    .busy(busy),
    .done(done),
    .bin_out(bin_out),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Leaves us at the falling edge right after the accepting edge.
  task automatic request(input logic [15:0] v);
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done();
    lat = 1;
    busy_n = 0;
    both = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) both++;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    bcd_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_inv", int'(invalid), 0);
    reset = 1'b0;

    request(16'h0000);
    wait_done();
    check("z_lat", lat, 15);
    check("z_busy", busy_n, 14);
    check("z_bin", int'(bin_out), 0);
    check("z_inv", int'(invalid), 0);
    check("z_both", both, 0);

    request(16'h9999);
    wait_done();
    check("n_lat", lat, 15);
    check("n_bin", int'(bin_out), 9999);

    request(16'h4095);
    check("hold_bin", int'(bin_out), 9999);
    wait_done();
    check("f_bin", int'(bin_out), 4095);
    request(16'h0001);
    wait_done();
    check("one_bin", int'(bin_out), 1);

    request(16'h12A4);
    wait_done();
    check("bad_lat", lat, 1);
    check("bad_busy", busy_n, 0);
    check("bad_inv", int'(invalid), 1);
    check("bad_bin", int'(bin_out), 0);
    request(16'h0042);
    check("bad_hold", int'(invalid), 1);
    wait_done();
    check("ok_inv", int'(invalid), 0);
    check("ok_bin", int'(bin_out), 42);

    request(16'h1234);
    repeat (3) @(negedge clk);
    bcd_in = 16'h5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    check("ign_done", int'(done), 1);
    check("ign_bin", int'(bin_out), 1234);
    bcd_in = 16'h5678;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    check("b2b_lat", lat, 15);
    check("b2b_bin", int'(bin_out), 5678);

    request(16'h8888);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("ab_busy", int'(busy), 0);
    check("ab_bin", int'(bin_out), 0);
    seen = 0;
    repeat (30) begin
      if (done) seen++;
      @(negedge clk);
    end
    check("ab_nodone", seen, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
